// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the RV32I instruction-fetch stage
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc : program counter with redirect / sequential-advance / hold mux
// Revision : 1.0
// ---------------------------------------------------------------------------
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Redirect outranks the sequential step; the low two bits are always cleared
  always_comb begin
    pc_d = pc_q;
    if (i_redirect) begin
      pc_d = i_redirect_pc & ALIGN_MASK;
    end else if (i_advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q <= P_RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : IF stage - one outstanding imem request, hold buffer, IF/ID reg
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000,
  parameter logic [31:0] P_NOP      = NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instruct
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic [31:0]  hold_q;
  logic         valid_q;
  logic [31:0]  id_pc_q;
  logic [31:0]  id_instr_q;

  logic         load;
  logic [31:0]  load_word;
  logic         capture;
  logic         advance;
  logic         fire;
  logic         slot_free;

  assign fire      = valid_q & i_id_ready;
  assign slot_free = ~valid_q | i_id_ready;

  fetch_pc #(
    .P_RESET_PC (P_RESET_PC)
  ) u_fetch_pc (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_advance     (advance),
    .o_pc          (pc)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_word = i_imem_rdata;
    capture   = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      REQ: begin
        if (i_imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          if (slot_free) begin
            load    = 1'b1;
            advance = 1'b1;
            state_d = REQ;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = hold_q;
          advance   = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (i_imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A redirect cancels any load; DROP is needed whenever a granted request
    // is still owed a response that must not reach decode.
    if (i_redirect) begin
      load    = 1'b0;
      capture = 1'b0;
      advance = 1'b0;
      unique case (state_q)
        REQ:     state_d = i_imem_gnt    ? DROP : REQ;
        WAIT:    state_d = i_imem_rvalid ? REQ  : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = i_imem_rvalid ? REQ  : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= 32'd0;
    end else if (i_redirect) begin
      hold_q <= 32'd0;
    end else if (capture) begin
      hold_q <= i_imem_rdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      id_pc_q    <= 32'd0;
      id_instr_q <= P_NOP;
    end else if (i_redirect) begin
      valid_q    <= 1'b0;
      id_instr_q <= P_NOP;
    end else if (load) begin
      valid_q    <= 1'b1;
      id_pc_q    <= pc;
      id_instr_q <= load_word;
    end else if (fire) begin
      valid_q    <= 1'b0;
      id_instr_q <= P_NOP;
    end
  end

  assign o_imem_req  = (state_q == REQ) & ~i_rst;
  assign o_imem_addr = pc;
  assign o_valid     = valid_q;
  assign o_pc        = id_pc_q;
  assign o_pc_plus4  = id_pc_q + PC_STEP;
  assign o_instruct  = id_instr_q;

  // Read data is only legal while a granted request is outstanding
  a_no_spurious_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (state_q == WAIT || state_q == DROP));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : randomized scoreboard bench for fetch_stage
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_id_ready;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_instruct;

  fetch_stage #(
    .P_RESET_PC (RESET_PC),
    .P_NOP      (NOP)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_id_ready    (i_id_ready),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_instruct    (o_instruct)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;

  // Memory image: two fixed words at the bottom, a hash elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Expected delivery stream: consecutive words starting at the fetch target
  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int k = 0; k < 512; k++) begin
      exp_q.push_back({p, mem_word(p)});
      p = p + 32'd4;
    end
  endtask

  // Memory model: one outstanding request, latency 1+[lat_min..lat_max] cycles
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          pend    = 1'b0;
  int          cnt     = 0;
  logic [31:0] paddr;
  logic [31:0] last_gnt_addr = 32'hFFFF_FFFF;

  initial begin : mem_model
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    forever begin
      @(negedge i_clk);
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
      if (i_rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(paddr);
          pend          = 1'b0;
        end else begin
          cnt--;
        end
      end else if (o_imem_req && (int'($urandom_range(99, 0)) < gnt_pct)) begin
        i_imem_gnt    = 1'b1;
        pend          = 1'b1;
        paddr         = o_imem_addr;
        last_gnt_addr = o_imem_addr;
        cnt           = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_imem_req) check32("addr_align", {30'd0, o_imem_addr[1:0]}, 32'd0);
        if (!o_valid) begin
          check32("idle_nop", o_instruct, NOP);
        end else if (i_id_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual pc=%08h required=<no entry>", o_pc);
          end else begin
            e = exp_q.pop_front();
            check32("out_pc", o_pc, e.pc);
            check32("out_instr", o_instruct, e.instr);
            check32("out_pc_plus4", o_pc_plus4, e.pc + 32'd4);
            delivered++;
          end
        end
      end
    end
  end

  // One clock of stimulus; the stream restarts at the edge where a redirect lands
  task automatic cyc(input logic rdy, input logic rd, input logic [31:0] tgt);
    i_id_ready    = rdy;
    i_redirect    = rd;
    i_redirect_pc = tgt;
    @(posedge i_clk);
    if (rd && !i_rst) refill(tgt & 32'hFFFF_FFFC);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    do begin
      cyc(1'b1, 1'b0, 32'h0);
      n++;
    end while (!i_imem_gnt && n < 60);
    if (!i_imem_gnt) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_grant required=grant", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check32({tag, "_instr"}, o_instruct, NOP);
    check32({tag, "_pc"}, o_pc, 32'h0);
    check32({tag, "_pc_plus4"}, o_pc_plus4, 32'h4);
    check32({tag, "_req"}, {31'd0, o_imem_req}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_id_ready    = 1'b1;
    refill(RESET_PC);
    #2;
    check_reset_outputs("reset");
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      check32("req_in_reset", {31'd0, o_imem_req}, 32'd0);
    end
    i_rst = 1'b0;

    // Zero-wait-state streaming, then a decode stall that forces HOLD
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 32'h0);

    // Redirect while waiting on a slow response
    lat_min = 2; lat_max = 2;
    wait_grant("wait_grant_slow");
    lat_min = 0; lat_max = 0;
    cyc(1'b1, 1'b1, 32'h0000_0100);
    wait_grant("wait_grant_0x100");
    check32("redirect_wait_addr", last_gnt_addr, 32'h0000_0100);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 32'h0);

    // Redirect in the very cycle the request is granted
    for (int k = 0; k < 20 && !o_imem_req; k++) cyc(1'b1, 1'b0, 32'h0);
    lat_min = 1; lat_max = 3;
    cyc(1'b1, 1'b1, 32'h0000_0203);
    lat_min = 0; lat_max = 0;
    wait_grant("wait_grant_0x200");
    check32("redirect_gnt_addr", last_gnt_addr, 32'h0000_0200);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 32'h0);

    // Wrap of the sequential PC
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_grant("wait_grant_wrap");
    check32("wrap_first_addr", last_gnt_addr, 32'hFFFF_FFFC);
    wait_grant("wait_grant_wrap2");
    check32("wrap_second_addr", last_gnt_addr, 32'h0000_0000);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 32'h0);

    // Asynchronous reset while a response is outstanding
    lat_min = 3; lat_max = 3;
    wait_grant("wait_grant_pre_rst");
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    refill(RESET_PC);
    lat_min = 0; lat_max = 0;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    i_rst = 1'b0;
    wait_grant("wait_grant_post_rst");
    check32("post_rst_addr", last_gnt_addr, RESET_PC);

    // Randomized traffic: grant jitter, latency, back-pressure, redirects
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 3), $urandom);
    end
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 32'h0);

    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL delivered_count actual=%0d required=>=100", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode_stage.
- Owns the PC register and issues one outstanding instruction-memory request at a time.
- Tolerates variable memory latency (grant/rvalid handshake) and holds the fetched word until decode accepts it.
- Presents {pc, instruction, pc+4} through an IF/ID output register with a valid/ready handshake.
- Supports redirect (branch/jump/flush), including discarding stale in-flight responses.

Parameters:
P_RESET_PC, 32'h0000_0000, PC value loaded on reset
P_NOP, 32'h0000_0013, instruction word driven while o_valid=0 (addi x0,x0,0)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_redirect  in  1  redirect request from EX (taken branch/jump/flush)
i_redirect_pc  in  32  target PC; bits[1:0] ignored (forced 0)
o_imem_req  out  1  memory request valid
o_imem_addr  out  32  request address (word aligned)
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  read data valid (at least 1 cycle after gnt)
i_imem_rdata  in  32  read data
o_valid  out  1  IF/ID register holds a valid instruction
i_id_ready  in  1  decode accepts IF/ID contents this cycle
o_pc  out  32  PC of o_instruct
o_pc_plus4  out  32  o_pc + 4, mod 2^32
o_instruct  out  32  instruction to decode_stage

Behaviour:
Reset (asynchronous, any state):
- pc=P_RESET_PC; state=REQ; o_valid=0; o_instruct=P_NOP; o_pc=0; o_pc_plus4=4; hold buffer cleared.
- o_imem_req=0 while i_rst=1.

FSM (registered):
- REQ: o_imem_req=1, o_imem_addr=pc. gnt -> WAIT; else stay.
- WAIT: o_imem_req=0. On rvalid:
  - output slot free (o_valid=0 or i_id_ready=1): load IF/ID {pc, rdata}, pc<=pc+4, go REQ.
  - otherwise: capture rdata into hold buffer, go HOLD.
- HOLD: o_imem_req=0. When o_valid=0 or i_id_ready=1: move buffer to IF/ID, pc<=pc+4, go REQ.
- DROP: o_imem_req=0. On rvalid: discard data, go REQ. pc already holds the redirect target.

IF/ID output register:
- Output fire = o_valid & i_id_ready.
- On fire with no new load: o_valid<=0, o_instruct<=P_NOP.
- o_valid & !i_id_ready: all outputs held stable.

Redirect (highest priority, evaluated every cycle):
- pc<=redirect_pc, o_valid<=0, o_instruct<=P_NOP, hold buffer cleared.
- Next state by current state:
  - REQ without gnt: REQ (new address next cycle).
  - REQ with gnt: DROP (old address was accepted).
  - WAIT without rvalid: DROP.
  - WAIT with rvalid: REQ (response discarded).
  - HOLD: REQ.
  - DROP: stays DROP until rvalid.
- A redirect in the same cycle as fire: decode still consumes the current word; the flush applies from the next cycle.
- Redirect while i_rst=1 is ignored.

Timing and arithmetic:
- Best-case latency: request cycle N, gnt at N, rvalid at N+1, o_valid at N+2.
- Throughput: 1 instruction per 2 cycles at zero wait states.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- o_imem_addr[1:0] is always 0.
- Spurious rvalid in REQ or HOLD is ignored. This case is flagged by a simulation-only assertion.

Decomposition:
- fetch_pkg:
  - typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_e
  - localparam NOP_INSTR = 32'h0000_0013
  - localparam PC_STEP = 32'd4
- Sub-module fetch_pc:
  - PC register with async reset and next-PC mux (redirect / +4 / hold).
  - Output pc.
- FSM, hold buffer and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, memory returns gnt immediately and rvalid 1 cycle later with words 0x00500093, 0x00A00113, i_id_ready=1 -> o_valid pulses with o_pc=0x0 then 0x4, o_pc_plus4=0x4/0x8; no request while i_rst=1.
- Decode stalls (i_id_ready=0 for 5 cycles) while a second word returns -> FSM enters HOLD; o_pc/o_instruct stay stable; after ready, PC 0x4 then 0x8 delivered in order with no loss or duplication.
- Redirect to 0x100 asserted in WAIT, rvalid arrives 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears; next o_imem_addr=0x100; next o_pc=0x100.
- Redirect to 0x203 in the same cycle as gnt in REQ -> state DROP; late response discarded; next request address 0x200.
- Redirect target 0xFFFFFFFC, then sequential fetch -> o_pc=0xFFFFFFFC, o_pc_plus4=0x0, next fetch address 0x0.
- Assert i_rst mid-WAIT -> all outputs immediately at reset values (o_valid=0, o_instruct=0x00000013); first request after release uses P_RESET_PC.
